seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, request to begin a multiply; sampled only in IDLE and DONE states.
REQ-004 SHALL have port A, input, 32, multiplicand; sampled on the accepted Start edge.
REQ-005 SHALL have port B, input, 32, multiplier; sampled on the accepted Start edge.
REQ-006 SHALL have port Busy, output, 1, high while an operation is in RUN.
REQ-007 SHALL have port Done, output, 1, one-cycle pulse when a result is valid.
REQ-008 SHALL have port High, output, 32, upper half of the 64-bit product.
REQ-009 SHALL have port Low, output, 32, lower half of the 64-bit product.

Function
REQ-010 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-011 SHALL, on a Start=1 edge in IDLE or DONE, do the following: latch A into a 32-bit multiplicand register, load a 65-bit product/shift register with {33'b0, B}, clear a 5-bit iteration counter, and enter RUN.
REQ-012 SHALL, on each RUN edge, add the multiplicand to product[64:32] when product[0]=1, then shift the 65-bit register right by 1 with zero fill, then increment the counter.
REQ-013 SHALL, after the 32nd RUN edge (counter wrapping from 31 to 0), enter DONE, load {High,Low} with product[63:0], and assert Done for exactly that one cycle.
REQ-014 SHALL have the following latency: Start sampled at edge N, Busy=1 from edge N+1 through edge N+32, and Done=1 in the cycle after edge N+32.
REQ-015 SHALL leave DONE on the next edge: it enters RUN if Start=1 (back-to-back operation, no idle cycle), otherwise it enters IDLE.
REQ-016 SHALL ignore Start while in RUN; A and B changes during RUN SHALL NOT affect the result.
REQ-017 SHALL hold High and Low at the last result until the next Done; they SHALL NOT show intermediate values.
REQ-018 SHALL drive Busy and Done directly from state decode, with no combinational path from Start.

Reset
REQ-019 SHALL, when Reset=0 at any time (including mid-RUN), immediately force state IDLE, Busy=0, Done=0, High=0, Low=0, counter=0, and clear the product and multiplicand registers.
REQ-020 SHALL accept its first Start on the first rising edge after Reset deasserts; no result from an aborted operation SHALL ever be output.

Configuration
REQ-021 SHALL provide macro SEQ_MULTIPLIER_SIGNED_EN, which adds input port Signed (1 bit, sampled with Start).
REQ-022 SHALL, with the macro defined and Signed=1, latch the absolute values of A and B, run the same 32 iterations, and two's-complement negate the 64-bit result when sign(A) XOR sign(B)=1 before loading High and Low; latency is unchanged.
REQ-023 SHALL, with the macro defined and Signed=1, produce 0x40000000_00000000 for A=B=0x80000000 (magnitude 2^31 handled as unsigned).
REQ-024 SHALL, without the macro, have no Signed port and treat all operands as unsigned.

Verification
REQ-025 SHALL cover: A=0x0000007F, B=0x00000070, Start pulse -> Done 33 cycles later, High=0x00000000, Low=0x00003790.
REQ-026 SHALL cover: A=B=0xFFFFFFFF unsigned -> High=0xFFFFFFFE, Low=0x00000001; Busy high for exactly 32 cycles.
REQ-027 SHALL cover: Start held high continuously with A=3, B=5 -> Done every 33 cycles, Low=0x0000000F each time, no IDLE cycle between operations.
REQ-028 SHALL cover: Start, then after 10 cycles pulse Start with new A/B -> the second Start is ignored and the result equals the first operands' product.
REQ-029 SHALL cover: Reset=0 asserted mid-RUN at iteration 15 -> Busy, Done, High and Low go to 0 asynchronously, and no Done pulse follows after release.
REQ-030 SHALL cover, with SEQ_MULTIPLIER_SIGNED_EN defined: Signed=1, A=0xFFFFFFFF, B=0x00000002 -> High=0xFFFFFFFF, Low=0xFFFFFFFE; with Signed=0 and the same operands -> High=0x00000001, Low=0xFFFFFFFE.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-and-add multiplier: 32 RUN cycles per product, one-cycle Done pulse.
// Define SEQ_MULTIPLIER_SIGNED_EN to add the Signed input (sign-magnitude signed multiply).
module seq_multiplier (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic        Signed,
`endif
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] High,
    output logic [31:0] Low
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [64:0] r_prod;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic [31:0] r_high;
    logic [31:0] r_low;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_neg_req;
    logic [32:0] w_add;
    logic [64:0] w_acc;
    logic [64:0] w_shift;
    logic [63:0] w_result;

    // Operand conditioning: signed mode multiplies magnitudes and fixes the sign at the end
    always_comb begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        w_a_mag   = (Signed && A[31]) ? (~A + 32'd1) : A;
        w_b_mag   = (Signed && B[31]) ? (~B + 32'd1) : B;
        w_neg_req = Signed & (A[31] ^ B[31]);
`else
        w_a_mag   = A;
        w_b_mag   = B;
        w_neg_req = 1'b0;
`endif
    end

    // One shift-and-add iteration plus the final sign correction of the completed product
    always_comb begin
        w_add    = r_prod[64:32] + {1'b0, r_mcand};
        w_acc    = r_prod[0] ? {w_add, r_prod[31:0]} : r_prod;
        w_shift  = {1'b0, w_acc[64:1]};
        w_result = r_neg ? (~w_shift[63:0] + 64'd1) : w_shift[63:0];
    end

    // Control FSM and datapath registers; High/Low only change when a product completes
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_mcand <= 32'd0;
            r_prod  <= 65'd0;
            r_cnt   <= 5'd0;
            r_neg   <= 1'b0;
            r_high  <= 32'd0;
            r_low   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_mcand <= w_a_mag;
                        r_prod  <= {33'd0, w_b_mag};
                        r_cnt   <= 5'd0;
                        r_neg   <= w_neg_req;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_prod <= w_shift;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_high  <= w_result[63:32];
                        r_low   <= w_result[31:0];
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = (r_state == S_RUN);
    assign Done = (r_state == S_DONE);
    assign High = r_high;
    assign Low  = r_low;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, random operands against a plain
// arithmetic reference, back-to-back, ignored mid-run Start and reset-abort sequences.
module tb_seq_multiplier;

    logic        clk_s;
    logic        rst_n_s;
    logic        start_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic        signed_s;
`endif
    logic        busy_s;
    logic        done_s;
    logic [31:0] high_s;
    logic [31:0] low_s;

    int          n_checks;
    int          n_errors;
    logic [63:0] last_res;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    seq_multiplier dut (
        .CLK    (clk_s),
        .Reset  (rst_n_s),
        .Start  (start_s),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .Signed (signed_s),
`endif
        .A      (a_s),
        .B      (b_s),
        .Busy   (busy_s),
        .Done   (done_s),
        .High   (high_s),
        .Low    (low_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width product of the (sign-extended when signed) operands
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag, input bit scramble, input int poke_at,
                          output logic [63:0] res);
        int          done_at;
        int          busy_cnt;
        int          hold_bad;
        logic [63:0] exp;
        exp      = ref_mul(a, b, s);
        done_at  = 0;
        busy_cnt = 0;
        hold_bad = 0;
        @(negedge clk_s);
        start_s = 1'b1;
        a_s     = a;
        b_s     = b;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        signed_s = s;
`endif
        @(negedge clk_s);
        for (int k = 1; k <= 40; k++) begin
            if (done_s) begin
                done_at = k;
                break;
            end
            if (busy_s) busy_cnt++;
            if ({high_s, low_s} !== last_res) hold_bad++;
            start_s = (k == poke_at);
            if (scramble || (k == poke_at)) begin
                a_s = $urandom;
                b_s = $urandom;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                signed_s = 1'($urandom_range(0, 1));
`endif
            end
            @(negedge clk_s);
        end
        start_s = 1'b0;
        res = {high_s, low_s};
        check({tag, " latency"}, 64'(done_at), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, " hold_during_run"}, 64'(hold_bad), 64'd0);
        check({tag, " product"}, res, exp);
        last_res = exp;
        @(negedge clk_s);
        check({tag, " done_one_cycle"}, 64'(done_s), 64'd0);
        check({tag, " idle_after"}, 64'(busy_s), 64'd0);
        check({tag, " hold_after"}, {high_s, low_s}, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic [31:0] ra;
        logic [31:0] rb;
        int          found;
        int          last_k;
        int          idle_seen;
        int          bad;

        n_checks = 0;
        n_errors = 0;
        last_res = 64'd0;
        vecs[0] = '{32'h0000007F, 32'h00000070, 64'h00000000_00003790};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'h12345678, 32'h00000000, 64'h00000000_00000000};
        vecs[3] = '{32'h00000001, 32'hDEADBEEF, 64'h00000000_DEADBEEF};
        vecs[4] = '{32'h00010000, 32'h00010000, 64'h00000001_00000000};
        vecs[5] = '{32'h80000000, 32'h00000002, 64'h00000001_00000000};

        rst_n_s = 1'b0;
        start_s = 1'b0;
        a_s     = 32'd0;
        b_s     = 32'd0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        signed_s = 1'b0;
`endif
        #12;
        check("reset busy", 64'(busy_s), 64'd0);
        check("reset done", 64'(done_s), 64'd0);
        check("reset high", 64'(high_s), 64'd0);
        check("reset low", 64'(low_s), 64'd0);
        @(negedge clk_s);
        rst_n_s = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), (i % 2) == 1, 0, res);
            check($sformatf("vec%0d table", i), res, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'b0, $sformatf("rand%0d", i), 1'b1, 0, res);
        end

        // Start held high: products back to back, 33 cycles apart, never passing through IDLE
        @(negedge clk_s);
        start_s = 1'b1;
        a_s     = 32'd3;
        b_s     = 32'd5;
        @(negedge clk_s);
        found     = 0;
        last_k    = 0;
        idle_seen = 0;
        for (int k = 1; k <= 120 && found < 3; k++) begin
            if (done_s) begin
                found++;
                check($sformatf("b2b interval%0d", found), 64'(k - last_k), 64'd33);
                check($sformatf("b2b result%0d", found), {high_s, low_s}, 64'h00000000_0000000F);
                last_k = k;
            end else if (!busy_s) begin
                idle_seen++;
            end
            @(negedge clk_s);
        end
        check("b2b count", 64'(found), 64'd3);
        check("b2b no_idle", 64'(idle_seen), 64'd0);
        check("b2b restarted", 64'(busy_s), 64'd1);
        start_s = 1'b0;
        for (int k = 0; k < 40 && !done_s; k++) @(negedge clk_s);
        check("b2b final", {64'(done_s), high_s, low_s} , {64'd1, 64'h00000000_0000000F});
        last_res = 64'h00000000_0000000F;
        @(negedge clk_s);

        ra = $urandom;
        rb = $urandom;
        run_op(ra, rb, 1'b0, "ignore_start", 1'b0, 10, res);

        // Reset asserted mid-run must clear everything at once and never produce a result
        run_op(32'hFFFFFFFF, 32'h00000003, 1'b0, "pre_abort", 1'b0, 0, res);
        @(negedge clk_s);
        start_s = 1'b1;
        a_s     = 32'h0000FFFF;
        b_s     = 32'h0000FFFF;
        @(negedge clk_s);
        start_s = 1'b0;
        repeat (15) @(negedge clk_s);
        check("abort running", 64'(busy_s), 64'd1);
        #2;
        rst_n_s = 1'b0;
        #1;
        check("abort busy", 64'(busy_s), 64'd0);
        check("abort done", 64'(done_s), 64'd0);
        check("abort high", 64'(high_s), 64'd0);
        check("abort low", 64'(low_s), 64'd0);
        @(negedge clk_s);
        rst_n_s  = 1'b1;
        last_res = 64'd0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_s);
            if (done_s || busy_s) bad++;
        end
        check("abort no_done", 64'(bad), 64'd0);
        check("abort result_zero", {high_s, low_s}, 64'd0);
        run_op(32'h00000007, 32'h00000009, 1'b0, "post_abort", 1'b0, 0, res);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        run_op(32'hFFFFFFFF, 32'h00000002, 1'b1, "signed_neg", 1'b1, 0, res);
        check("signed_neg table", res, 64'hFFFFFFFF_FFFFFFFE);
        run_op(32'hFFFFFFFF, 32'h00000002, 1'b0, "unsigned_same", 1'b1, 0, res);
        check("unsigned_same table", res, 64'h00000001_FFFFFFFE);
        run_op(32'h80000000, 32'h80000000, 1'b1, "signed_min", 1'b0, 0, res);
        check("signed_min table", res, 64'h40000000_00000000);
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'b1, $sformatf("srand%0d", i), 1'b1, 0, res);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
